// File: rtl/serial_sub_nbit.sv
// serial_sub_nbit: multi-cycle N-bit subtractor computing a - b - bin,
// DIGIT bits per clock, LSB first, with the borrow held in a register
// between digits. start/ready/done handshake; borrow, signed-overflow
// and zero flags are produced alongside the difference.
module serial_sub_nbit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int K     = WIDTH / DIGIT;
    localparam int CNT_W = (K > 1) ? $clog2(K + 1) : 1;

    // Reject parameter sets that cannot be split into whole digits.
    if (((WIDTH % DIGIT) != 0) || (WIDTH < 2) || (DIGIT < 1)) begin : g_bad_param
        $error("serial_sub_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic    [WIDTH-1:0]     r_a;
    logic    [WIDTH-1:0]     r_b;
    logic    [WIDTH-1:0]     r_res;
    logic                    r_borrow;
    logic    [CNT_W-1:0]     r_cnt;
    logic                    r_done;
    logic    [WIDTH-1:0]     r_diff;
    logic                    r_bout;
    logic                    r_ovf;
    logic                    r_zero;

    logic    [DIGIT-1:0]     w_ad;
    logic    [DIGIT-1:0]     w_bd;
    logic    [DIGIT:0]       w_step;
    logic                    w_bmsb;
    logic    [WIDTH-1:0]     w_res_next;
    logic                    w_last;

    assign w_ad = r_a[DIGIT-1:0];
    assign w_bd = r_b[DIGIT-1:0];

    // One digit of subtraction; the extra top bit of the difference is the
    // borrow out of this digit (set whenever the digit result went negative).
    assign w_step = {1'b0, w_ad} - {1'b0, w_bd} - (DIGIT+1)'(r_borrow);

    // Borrow entering the top bit of the current digit. With single-bit
    // digits that is just the incoming borrow; otherwise it comes from the
    // low DIGIT-1 bits of the digit.
    if (DIGIT > 1) begin : g_multi
        logic [DIGIT-1:0] w_low;
        assign w_low  = {1'b0, w_ad[DIGIT-2:0]} - {1'b0, w_bd[DIGIT-2:0]}
                        - DIGIT'(r_borrow);
        assign w_bmsb = w_low[DIGIT-1];
    end else begin : g_single
        assign w_bmsb = r_borrow;
    end

    // New digits enter the result from the MSB end, so after K steps the
    // first digit computed has reached bit 0.
    assign w_res_next = (r_res >> DIGIT)
                      | (WIDTH'(w_step[DIGIT-1:0]) << (WIDTH - DIGIT));

    assign w_last  = (r_cnt == CNT_W'(K - 1));
    assign o_ready = (r_state == S_IDLE);

    assign o_done = r_done;
    assign o_diff = r_diff;
    assign o_bout = r_bout;
    assign o_ovf  = r_ovf;
    assign o_zero = r_zero;

    // Control FSM plus digit datapath; result registers load only on the
    // transition into DONE so they hold through IDLE and the next RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_borrow <= i_bin;
                        r_res    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res    <= w_res_next;
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_borrow <= w_step[DIGIT];
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_diff  <= w_res_next;
                        r_bout  <= w_step[DIGIT];
                        r_ovf   <= w_bmsb ^ w_step[DIGIT];
                        r_zero  <= (w_res_next == '0);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Bench for serial_sub_nbit: two instances (8-bit with 1-bit and 4-bit
// digits) sharing clock and reset; expected results come from a queue
// filled by an arithmetic model at the time each request is issued.
module tb_serial_sub_nbit;

    logic       clk = 1'b0;
    logic       rst;
    logic       s1, s4;
    logic [7:0] a1, b1, a4, b4;
    logic       bin1, bin4;
    logic       r1, d1, bo1, ov1, z1;
    logic       r4, d4, bo4, ov4, z4;
    logic [7:0] diff1, diff4;

    always #5 clk = ~clk;

    serial_sub_nbit #(.WIDTH(8), .DIGIT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(s1), .i_a(a1), .i_b(b1), .i_bin(bin1),
        .o_ready(r1), .o_done(d1), .o_diff(diff1), .o_bout(bo1), .o_ovf(ov1), .o_zero(z1)
    );

    serial_sub_nbit #(.WIDTH(8), .DIGIT(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(s4), .i_a(a4), .i_b(b4), .i_bin(bin4),
        .o_ready(r4), .o_done(d4), .o_diff(diff4), .o_bout(bo4), .o_ovf(ov4), .o_zero(z4)
    );

    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        logic       zero;
    } res_t;

    res_t q1[$];
    res_t q4[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   dc1 = 0;
    int   dc4 = 0;

    always @(posedge clk) begin
        if (d1) dc1 <= dc1 + 1;
        if (d4) dc4 <= dc4 + 1;
    end

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        res_t       r;
        logic [8:0] full;
        int         s;
        full   = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        s      = int'($signed(a)) - int'($signed(b)) - (bin ? 1 : 0);
        r.diff = full[7:0];
        r.bout = full[8];
        r.ovf  = (s < -128) || (s > 127);
        r.zero = (full[7:0] == 8'd0);
        return r;
    endfunction

    function automatic res_t get_res(input int sel);
        res_t r;
        if (sel == 4) r = {diff4, bo4, ov4, z4};
        else          r = {diff1, bo1, ov1, z1};
        return r;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 4) ? d4 : d1;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 4) ? r4 : r1;
    endfunction

    // Raise start at the current time (caller is at a falling edge) and
    // record the expected result.
    task automatic drive_start(input int sel, input logic [7:0] a, input logic [7:0] b,
                               input logic bin);
        if (sel == 4) begin
            s4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
            q4.push_back(model(a, b, bin));
        end else begin
            s1 = 1'b1; a1 = a; b1 = b; bin1 = bin;
            q1.push_back(model(a, b, bin));
        end
    endtask

    // Watch falling edges first_idx..K+3 after the request; done must be
    // seen exactly at K+1, then results compared and ready checked.
    task automatic wait_result(input int sel, input int k, input int first_idx, input string name);
        int   cyc;
        bit   seen;
        res_t got, exp_r;
        cyc  = 0;
        seen = 1'b0;
        for (int i = first_idx; i <= k + 3; i++) begin
            @(negedge clk);
            s1 = 1'b0;
            s4 = 1'b0;
            if (get_done(sel)) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen || cyc != k + 1) begin
            n_fail++;
            $display("FAIL %s latency: done at cycle %0d (seen=%0d), required cycle %0d",
                     name, cyc, seen, k + 1);
        end
        if (sel == 4) exp_r = (q4.size() > 0) ? q4.pop_front() : '0;
        else          exp_r = (q1.size() > 0) ? q1.pop_front() : '0;
        if (seen) begin
            got = get_res(sel);
            n_tests++;
            if (got !== exp_r) begin
                n_fail++;
                $display("FAIL %s result: got diff=%h bout=%b ovf=%b zero=%b, required diff=%h bout=%b ovf=%b zero=%b",
                         name, got.diff, got.bout, got.ovf, got.zero,
                         exp_r.diff, exp_r.bout, exp_r.ovf, exp_r.zero);
            end
            @(negedge clk);
            n_tests++;
            if (get_ready(sel) !== 1'b1 || get_done(sel) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after-done: ready=%b done=%b, required ready=1 done=0",
                         name, get_ready(sel), get_done(sel));
            end
        end
    endtask

    task automatic check_cleared(input string name);
        n_tests++;
        if (r1 !== 1'b1 || d1 !== 1'b0 || get_res(1) !== res_t'(0) ||
            r4 !== 1'b1 || d4 !== 1'b0 || get_res(4) !== res_t'(0)) begin
            n_fail++;
            $display("FAIL %s: ready=%b/%b done=%b/%b res=%h/%h, required ready=1 done=0 res=0",
                     name, r1, r4, d1, d4, get_res(1), get_res(4));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        s4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_cleared("reset_state");
    endtask

    task automatic test_basic();
        @(negedge clk);
        drive_start(1, 8'h05, 8'h03, 1'b0);
        wait_result(1, 8, 1, "basic_05_03");
    endtask

    task automatic test_borrow_ovf();
        @(negedge clk);
        drive_start(1, 8'h00, 8'h01, 1'b0);
        wait_result(1, 8, 1, "borrow_00_01");
        drive_start(1, 8'h80, 8'h01, 1'b0);
        wait_result(1, 8, 1, "ovf_80_01");
    endtask

    task automatic test_bin_zero();
        @(negedge clk);
        drive_start(1, 8'h10, 8'h0F, 1'b1);
        wait_result(1, 8, 1, "bin_zero_10_0F");
    endtask

    task automatic test_multi_digit();
        @(negedge clk);
        drive_start(4, 8'h3C, 8'hC3, 1'b0);
        wait_result(4, 2, 1, "digit4_3C_C3");
        drive_start(4, 8'h80, 8'h01, 1'b0);
        wait_result(4, 2, 1, "digit4_80_01");
        drive_start(4, 8'h10, 8'h0F, 1'b1);
        wait_result(4, 2, 1, "digit4_bin_zero");
    endtask

    task automatic test_busy_hold();
        int d0;
        @(negedge clk);
        d0 = dc1;
        drive_start(1, 8'h05, 8'h03, 1'b0);
        @(negedge clk);
        s1 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (r1 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready: ready=%b, required 0", r1);
        end
        s1 = 1'b1; a1 = 8'hAA; b1 = 8'h01; bin1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0; a1 = 8'hFF; b1 = 8'hFF;
        wait_result(1, 8, 4, "busy_reject");
        repeat (12) @(negedge clk);
        n_tests++;
        if (dc1 - d0 != 1 || diff1 !== 8'h02) begin
            n_fail++;
            $display("FAIL busy_hold: done pulses=%0d diff=%h, required pulses=1 diff=02",
                     dc1 - d0, diff1);
        end
        drive_start(1, 8'h09, 8'h04, 1'b0);
        repeat (4) @(negedge clk);
        s1 = 1'b0;
        n_tests++;
        if (diff1 !== 8'h02) begin
            n_fail++;
            $display("FAIL hold_during_run: diff=%h, required 02", diff1);
        end
        wait_result(1, 8, 5, "after_hold_09_04");
    endtask

    task automatic test_reset_mid();
        int d0;
        @(negedge clk);
        d0 = dc1;
        s1 = 1'b1; a1 = 8'h77; b1 = 8'h11; bin1 = 1'b0;
        @(negedge clk);
        s1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared("reset_mid_run");
        repeat (12) @(negedge clk);
        n_tests++;
        if (dc1 != d0 || r1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: done pulses=%0d ready=%b, required 0 and 1",
                     dc1 - d0, r1);
        end
        drive_start(1, 8'h09, 8'h04, 1'b0);
        wait_result(1, 8, 1, "post_reset_09_04");
    endtask

    task automatic test_rst_start();
        int d0;
        d0 = dc1;
        rst = 1'b1;
        s1 = 1'b1; a1 = 8'h05; b1 = 8'h01; bin1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        s1 = 1'b0;
        check_cleared("rst_with_start");
        repeat (12) @(negedge clk);
        n_tests++;
        if (dc1 != d0 || diff1 !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_start_dropped: done pulses=%0d diff=%h, required 0 and 00",
                     dc1 - d0, diff1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic       bi;
        @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            bi = 1'($urandom_range(0, 1));
            drive_start(1, a, b, bi);
            wait_result(1, 8, 1, "b2b_digit1");
        end
        for (int n = 0; n < 6; n++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            bi = 1'($urandom_range(0, 1));
            drive_start(4, a, b, bi);
            wait_result(4, 2, 1, "b2b_digit4");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_ovf();
        test_bin_zero();
        test_multi_digit();
        test_busy_hold();
        test_reset_mid();
        test_rst_start();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sub_nbit.md
# serial_sub_nbit

Parametrised multi-cycle subtractor: computes `diff = a - b - bin` over `WIDTH` bits by processing `DIGIT` bits per clock, LSB first, with the borrow carried between cycles in a register. It generalises the 1-bit full-subtractor cell into an N-bit sequential datapath. It has a start/ready/done handshake and borrow, signed-overflow and zero flags. It sits in the arithmetic group beside the combinational subtractor cells, for area-constrained paths where latency is acceptable.

## Interface
- `WIDTH`, 16: operand/result width in bits; ≥ 2.
- `DIGIT`, 1: bits processed per cycle. `WIDTH % DIGIT == 0` is required; elaboration fails otherwise. Define `K = WIDTH/DIGIT`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only when `ready` = 1.
- `a`  in  WIDTH  minuend. Latched on the accepted `start`.
- `b`  in  WIDTH  subtrahend. Latched on the accepted `start`.
- `bin`  in  1  borrow-in. Latched on the accepted `start`.
- `ready`  out  1  high iff FSM is in IDLE; combinational from state.
- `done`  out  1  one-cycle pulse marking that the results are valid.
- `diff`  out  WIDTH  result `a - b - bin` mod 2^WIDTH.
- `bout`  out  1  unsigned borrow-out: 1 iff `a < b + bin`.
- `ovf`  out  1  signed overflow: 1 iff the two's-complement value `a - b - bin` lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- `zero`  out  1  1 iff `diff == 0`.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **Reset:**
  - State goes to IDLE.
  - `diff`, `bout`, `ovf`, `zero`, `done` all reset to 0; `ready` = 1.
  - Operand shift registers, borrow register and digit counter reset to 0.
- **IDLE:**
  - On `start` = 1: latch `a`, `b`, `bin` into the operand and borrow registers, clear the counter, go to RUN.
  - Otherwise remain in IDLE.
- **RUN, each cycle:**
  - Take the low `DIGIT` bits of the a-reg and b-reg.
  - Compute `{borrow', d} = a_d - b_d - borrow` (`DIGIT`+1-bit arithmetic).
  - Shift `d` into the result register from the MSB end.
  - Shift the a-reg and b-reg right by `DIGIT`.
  - Update the borrow register and increment the counter.
- **Last digit (counter == K-1):**
  - Record the borrow into the MSB position: the internal borrow just before the final bit, i.e. inside the final digit when `DIGIT` > 1.
  - Go to DONE.
  - Load the output registers with: `diff` = completed result; `bout` = final borrow; `ovf` = (borrow into MSB) XOR (borrow out of MSB); `zero` = (result == 0).
- **DONE:** `done` = 1 for exactly this cycle, then go to IDLE.
- **Result hold:** `diff`, `bout`, `ovf`, `zero` change only on entry to DONE or on `rst`. They hold their values through IDLE and through the following RUN.
- **Busy rejection:** `start` while in RUN or DONE is ignored. No queuing, and no error flag.
- **Input changes:** changes on `a`, `b`, `bin` after acceptance have no effect.

## Timing
- **Latency:** `start` sampled at edge E0 gives RUN for edges E1…EK. DONE state, `done` = 1 and the new results are visible in the cycle after edge EK.
- **Throughput:** `ready` returns in the cycle after DONE, so a new request can be accepted at edge EK+2. Throughput is one operation per K+2 cycles.
- **`DIGIT` = `WIDTH`:** K = 1, so RUN lasts one cycle.
- **Reset mid-operation:** `rst` in RUN or DONE aborts to IDLE at that edge. The partial result is discarded and outputs are zeroed. `done` is never asserted for an aborted operation.
- **Simultaneous `rst` and `start`:** `rst` wins; the request is dropped.
- **Counter:** wide enough for K with no wrap; it is never compared beyond K-1.

## Test plan
- **Basic subtract:** `WIDTH`=8, `DIGIT`=1; `a`=0x05, `b`=0x03, `bin`=0 → after 8 RUN cycles `done` pulses once; `diff`=0x02, `bout`=0, `ovf`=0, `zero`=0; `ready` high the next cycle.
- **Unsigned borrow and signed overflow:** `WIDTH`=8, `DIGIT`=1.
  - 0x00 − 0x01, `bin`=0 → `diff`=0xFF, `bout`=1, `ovf`=0.
  - Then 0x80 − 0x01 → `diff`=0x7F, `bout`=0, `ovf`=1.
- **Borrow-in and zero flag:** `WIDTH`=8, `DIGIT`=1; `a`=0x10, `b`=0x0F, `bin`=1 → `diff`=0x00, `zero`=1, `bout`=0, `ovf`=0.
- **Multi-bit digit:** `WIDTH`=8, `DIGIT`=4; `a`=0x3C, `b`=0xC3, `bin`=0 → `done` appears 2 cycles after acceptance; `diff`=0x79, `bout`=1, `ovf`=0.
- **Busy rejection and hold:** during RUN of 0x05 − 0x03, assert `start` with `a`=0xAA, `b`=0x01 → ignored; result is still 0x02. Outputs hold 0x02 until the next accepted `start` completes.
- **Reset mid-operation:** assert `rst` for one cycle at RUN cycle 3 → next cycle shows `ready`=1 and all outputs 0. No `done` pulse. A following 0x09 − 0x04 yields 0x05.
